adc_scan_ctrl: RTL and testbench
================================

Name: adc_scan_ctrl

Overview:
- Round-robin conversion scheduler for the bench ADC model, an 8-stage, 8-bit delay pipe on the p0_in to XRAM data path.
- Walks a channel mask and issues one start strobe plus channel number per conversion.
- Waits out the fixed conversion latency, then captures the ADC byte into a per-channel result register.
- Presents results to the 8051 XRAM side through a strobed read port with valid and overrun tracking.

Parameters:
- NUM_CH, 4: number of channels (2..8).
- CH_W, 2: channel index width, equal to clog2(NUM_CH).
- CONV_CYCLES, 8: cycles from adc_start to a valid adc_data. Must be at least 1; 8 matches the delay pipe depth.

Ports:
- clk, in, 1: single clock, rising edge.
- rst, in, 1: asynchronous, active-low reset.
- scan_en, in, 1: enables continuous scanning.
- ch_mask, in, NUM_CH: enabled channels. Sampled at the start of each pass.
- adc_start, out, 1: one-cycle conversion start strobe.
- adc_ch, out, CH_W: channel being converted. Held from the START cycle through the CAPTURE cycle.
- adc_data, in, 8: ADC result bus (delay pipe output).
- eoc, out, 1: one-cycle pulse on each capture.
- scan_done, out, 1: one-cycle pulse when a pass completes.
- busy, out, 1: high in any state other than IDLE.
- cpu_rd, in, 1: read strobe.
- cpu_rd_ch, in, CH_W: channel to read.
- cpu_rd_data, out, 8: registered read data.
- cpu_rd_valid, out, 1: valid flag of the channel read, registered alongside cpu_rd_data.
- ovr, out, NUM_CH: sticky per-channel overrun flags.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - All outputs are 0 and adc_ch is 0.
  - Results, valid bits, ovr and the round-robin pointer (ptr) are cleared.
  - A reset mid-conversion abandons the conversion; no eoc is produced.
- FSM states: IDLE, SELECT, START, WAIT, CAPTURE.
- IDLE:
  - If scan_en=1 and ch_mask is non-zero: latch pend=ch_mask and go to SELECT.
  - Otherwise stay in IDLE.
- SELECT (1 cycle):
  - Choose the lowest set bit of pend at or above ptr, wrapping around to bit 0.
  - Drive it onto adc_ch and go to START.
- START (1 cycle):
  - adc_start=1.
  - Load cnt=CONV_CYCLES-1 and go to WAIT.
- WAIT:
  - Decrement cnt each cycle.
  - When cnt=0, go to CAPTURE.
  - WAIT lasts exactly CONV_CYCLES cycles.
- CAPTURE (1 cycle):
  - Sample adc_data into result[adc_ch] and set valid[adc_ch]=1.
  - eoc=1.
  - Clear pend[adc_ch] and set ptr=adc_ch+1, wrapping NUM_CH-1 to 0.
- Latency: with adc_start high in cycle T, the capture happens in cycle T+CONV_CYCLES+1 and eoc is high in that same cycle.
- Leaving CAPTURE:
  - If pend is now empty: scan_done=1. Then, if scan_en=1 and ch_mask is non-zero, re-latch pend and go to SELECT; otherwise go to IDLE.
  - If pend is not empty: go to SELECT.
- scan_en deasserted mid-pass: the current conversion completes, then the FSM goes to IDLE. pend is discarded and scan_done is not pulsed.
- ch_mask changes mid-pass are ignored until the next pass.
- CPU read:
  - On cpu_rd=1, in the next cycle cpu_rd_data=result[cpu_rd_ch] and cpu_rd_valid=valid[cpu_rd_ch].
  - valid[cpu_rd_ch] is cleared after the read.
  - Without cpu_rd, cpu_rd_data and cpu_rd_valid hold their values.
- Overrun: ovr[c] is set when a capture to channel c occurs while valid[c]=1 and no read of c is happening in the same cycle. It is cleared only by reset.
- Capture and read of the same channel in the same cycle:
  - The read returns the old result with valid=1.
  - The new capture wins: valid stays 1.
  - No overrun is flagged.

Optional Feature:
- Macro: ADC_SCAN_AVG_EN.
- When defined:
  - CAPTURE writes result[c] = (result[c] + adc_data + 1) >> 1, using a 9-bit sum and rounding half-up.
  - The first capture after reset, or after a read cleared valid[c], writes adc_data directly.
- When not defined: CAPTURE writes adc_data directly.

Test Plan:
1. Single channel: NUM_CH=4, ch_mask=0001, adc_data=0x5A, scan_en pulsed through one pass.
   - adc_start at cycle T, eoc and scan_done at T+9, busy high from T-1 to T+9.
   - cpu_rd ch0 then returns 0x5A with valid=1; a second read returns valid=0.
2. Round-robin: ch_mask=1011, adc_data=channel index+0x10.
   - adc_ch sequence 0,1,3,0,1,3.
   - scan_done after every third eoc.
   - Results read back as 0x10, 0x11, 0x13.
3. Overrun: continuous scan of ch_mask=0100 with no reads. ovr[2] is set on the second capture and stays set after a read.
4. Mid-pass stop: ch_mask=1111, scan_en dropped during the WAIT of ch1.
   - The ch1 eoc still occurs, then the FSM returns to IDLE.
   - No adc_start for ch2, no scan_done.
5. Reset mid-WAIT: rst low for 1 cycle. All outputs read 0 immediately, no eoc, and the next pass starts at ch0.
6. ADC_SCAN_AVG_EN: ch0 captures 0x40 then 0x81 with no read in between, so result reads 0x61.

Source files
------------

// File: rtl/adc_scan_ctrl.sv
// Round-robin ADC scan scheduler with per-channel result registers and a strobed CPU read port.
// Latency: adc_start in cycle T, capture/eoc in T+CONV_CYCLES+1; read data one cycle after cpu_rd.
// No backpressure: unread results are overwritten and flagged in ovr. Optional ADC_SCAN_AVG_EN averages captures.
module adc_scan_ctrl #(
    parameter int NUM_CH      = 4,
    parameter int CH_W        = 2,
    parameter int CONV_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scan_en,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic              adc_start,
    output logic [CH_W-1:0]   adc_ch,
    input  logic [7:0]        adc_data,
    output logic              eoc,
    output logic              scan_done,
    output logic              busy,
    input  logic              cpu_rd,
    input  logic [CH_W-1:0]   cpu_rd_ch,
    output logic [7:0]        cpu_rd_data,
    output logic              cpu_rd_valid,
    output logic [NUM_CH-1:0] ovr
);

    localparam int CNT_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, SELECT, START, WAIT, CAPTURE} state_t;

    state_t            state;
    logic [NUM_CH-1:0] pend;
    logic [CH_W-1:0]   ptr;
    logic [CNT_W-1:0]  cnt;
    logic [7:0]        result [NUM_CH];
    logic [NUM_CH-1:0] valid;

    logic [CH_W-1:0]   sel_ch;
    logic              found;
    int                idx;
    logic [CH_W-1:0]   idx_c;
    logic [NUM_CH-1:0] ch_bit;
    logic [NUM_CH-1:0] pend_clr;
    logic [CH_W-1:0]   ptr_nxt;
    logic [7:0]        cap_val;
    logic              capture;
    logic              rd_hit;

    // First pending channel at or after ptr, wrapping past the top channel.
    always_comb begin
        sel_ch = '0;
        found  = 1'b0;
        idx    = 0;
        idx_c  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            idx_c = CH_W'(idx);
            if (!found && pend[idx_c]) begin
                sel_ch = idx_c;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        ch_bit         = '0;
        ch_bit[adc_ch] = 1'b1;
    end

    assign pend_clr = pend & ~ch_bit;
    assign ptr_nxt  = (adc_ch == CH_W'(NUM_CH - 1)) ? '0 : adc_ch + 1'b1;
    assign capture  = (state == CAPTURE);
    assign rd_hit   = cpu_rd && (cpu_rd_ch == adc_ch);

`ifdef ADC_SCAN_AVG_EN
    // A channel with no unread result starts a fresh average from the raw sample.
    assign cap_val = valid[adc_ch] ? 8'((9'(result[adc_ch]) + 9'(adc_data) + 9'd1) >> 1) : adc_data;
`else
    assign cap_val = adc_data;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            pend      <= '0;
            ptr       <= '0;
            cnt       <= '0;
            adc_start <= 1'b0;
            adc_ch    <= '0;
            eoc       <= 1'b0;
            scan_done <= 1'b0;
            busy      <= 1'b0;
        end else begin
            adc_start <= 1'b0;
            eoc       <= 1'b0;
            scan_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (scan_en && |ch_mask) begin
                        pend  <= ch_mask;
                        busy  <= 1'b1;
                        state <= SELECT;
                    end
                end
                SELECT: begin
                    adc_ch    <= sel_ch;
                    adc_start <= 1'b1;
                    state     <= START;
                end
                START: begin
                    cnt   <= CNT_W'(CONV_CYCLES - 1);
                    state <= WAIT;
                end
                WAIT: begin
                    if (cnt == '0) begin
                        eoc       <= 1'b1;
                        scan_done <= ~|pend_clr;
                        state     <= CAPTURE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                CAPTURE: begin
                    pend <= pend_clr;
                    ptr  <= ptr_nxt;
                    if (~|pend_clr) begin
                        if (scan_en && |ch_mask) begin
                            pend  <= ch_mask;
                            state <= SELECT;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else if (scan_en) begin
                        state <= SELECT;
                    end else begin
                        pend  <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // The capture assignments come last so a same-cycle read of that channel leaves valid set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) result[i] <= '0;
            valid        <= '0;
            ovr          <= '0;
            cpu_rd_data  <= '0;
            cpu_rd_valid <= 1'b0;
        end else begin
            if (cpu_rd) begin
                cpu_rd_data       <= result[cpu_rd_ch];
                cpu_rd_valid      <= valid[cpu_rd_ch];
                valid[cpu_rd_ch]  <= 1'b0;
            end
            if (capture) begin
                result[adc_ch] <= cap_val;
                valid[adc_ch]  <= 1'b1;
                if (valid[adc_ch] && !rd_hit) ovr[adc_ch] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Bench for adc_scan_ctrl: directed scenarios plus random scanning/reads against a timestamp-based model.
module tb_adc_scan_ctrl;
    localparam int NCH  = 4;
    localparam int CW   = 2;
    localparam int CONV = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           scan_en = 1'b0;
    logic [NCH-1:0] ch_mask = '0;
    logic           adc_start;
    logic [CW-1:0]  adc_ch;
    logic [7:0]     adc_data = '0;
    logic           eoc;
    logic           scan_done;
    logic           busy;
    logic           cpu_rd = 1'b0;
    logic [CW-1:0]  cpu_rd_ch = '0;
    logic [7:0]     cpu_rd_data;
    logic           cpu_rd_valid;
    logic [NCH-1:0] ovr;

    always #5 clk = ~clk;

    adc_scan_ctrl #(.NUM_CH(NCH), .CH_W(CW), .CONV_CYCLES(CONV)) dut (
        .clk(clk), .rst(rst), .scan_en(scan_en), .ch_mask(ch_mask),
        .adc_start(adc_start), .adc_ch(adc_ch), .adc_data(adc_data),
        .eoc(eoc), .scan_done(scan_done), .busy(busy),
        .cpu_rd(cpu_rd), .cpu_rd_ch(cpu_rd_ch), .cpu_rd_data(cpu_rd_data),
        .cpu_rd_valid(cpu_rd_valid), .ovr(ovr)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Model: a conversion is anchored at its select cycle; everything else is an offset from it.
    bit             m_act;
    int             m_tsel;
    int             m_cur;
    logic [NCH-1:0] m_pend;
    int             m_ptr;
    logic [7:0]     m_res [NCH];
    logic [NCH-1:0] m_val;
    logic [NCH-1:0] m_ovr;
    logic [7:0]     m_rdd;
    logic           m_rdv;
    int             n = 0;

    int         data_mode = 0;
    logic [7:0] data_fix = '0;
    int         eoc_cnt = 0;
    int         done_cnt = 0;
    int         starts[$];

    function automatic int pick(input logic [NCH-1:0] p, input int from);
        for (int i = 0; i < NCH; i++) begin
            int c = (from + i) % NCH;
            if (p[c]) return c;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_act = 0; m_tsel = 0; m_cur = 0; m_pend = '0; m_ptr = 0;
        m_val = '0; m_ovr = '0; m_rdd = '0; m_rdv = 1'b0;
        for (int i = 0; i < NCH; i++) m_res[i] = '0;
    endtask

    task automatic begin_conv();
        m_tsel = n + 1;
        m_cur  = pick(m_pend, m_ptr);
    endtask

    task automatic tick();
        int             o;
        logic           exp_eoc;
        logic [NCH-1:0] left;
        logic           old_v;
        @(negedge clk);
        o       = n - m_tsel;
        exp_eoc = m_act && (o == CONV + 2);
        left    = m_pend & ~(NCH'(1) << m_cur);
        check("busy", busy, m_act);
        check("adc_start", adc_start, m_act && (o == 1));
        check("eoc", eoc, exp_eoc);
        check("scan_done", scan_done, exp_eoc && (left == '0));
        if (m_act && o >= 1) check("adc_ch", adc_ch, m_cur);
        check("rd_data", cpu_rd_data, m_rdd);
        check("rd_valid", cpu_rd_valid, m_rdv);
        check("ovr", ovr, m_ovr);
        if (adc_start) starts.push_back(int'(adc_ch));
        if (eoc) eoc_cnt++;
        if (scan_done) done_cnt++;

        if (cpu_rd) begin
            m_rdd = m_res[cpu_rd_ch];
            m_rdv = m_val[cpu_rd_ch];
        end
        if (exp_eoc) begin
            old_v = m_val[m_cur];
            if (cpu_rd) m_val[cpu_rd_ch] = 1'b0;
            if (old_v && !(cpu_rd && int'(cpu_rd_ch) == m_cur)) m_ovr[m_cur] = 1'b1;
`ifdef ADC_SCAN_AVG_EN
            if (old_v) m_res[m_cur] = 8'((int'(m_res[m_cur]) + int'(adc_data) + 1) / 2);
            else       m_res[m_cur] = adc_data;
`else
            m_res[m_cur] = adc_data;
`endif
            m_val[m_cur] = 1'b1;
            m_pend = left;
            m_ptr  = (m_cur + 1) % NCH;
            if (left == '0) begin
                if (scan_en && ch_mask != '0) begin
                    m_pend = ch_mask;
                    begin_conv();
                end else begin
                    m_act = 0;
                end
            end else if (scan_en) begin
                begin_conv();
            end else begin
                m_act = 0;
            end
        end else begin
            if (cpu_rd) m_val[cpu_rd_ch] = 1'b0;
            if (!m_act && scan_en && ch_mask != '0) begin
                m_act  = 1;
                m_pend = ch_mask;
                begin_conv();
            end
        end
        n++;
        @(posedge clk);
        #1;
        // ADC data only changes outside a conversion window so it is stable until capture.
        if (!m_act || m_tsel == n) begin
            case (data_mode)
                1:       adc_data = data_fix;
                2:       adc_data = 8'(8'h10 + m_cur);
                default: adc_data = 8'($urandom);
            endcase
        end
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_start"}, adc_start, 0);
        check({tag, "_eoc"}, eoc, 0);
        check({tag, "_done"}, scan_done, 0);
        check({tag, "_ch"}, adc_ch, 0);
        check({tag, "_rdd"}, cpu_rd_data, 0);
        check({tag, "_rdv"}, cpu_rd_valid, 0);
        check({tag, "_ovr"}, ovr, 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk_zero("rst_async");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        starts.delete();
        eoc_cnt = 0;
        done_cnt = 0;
    endtask

    task automatic wait_idle(input int maxc);
        int k = 0;
        while (m_act && k < maxc) begin tick(); k++; end
        check("timeout_idle", m_act, 0);
    endtask

    task automatic wait_eocs(input int target, input int maxc);
        int k = 0;
        while (eoc_cnt < target && k < maxc) begin tick(); k++; end
        check("timeout_eoc", eoc_cnt >= target, 1);
    endtask

    task automatic wait_starts(input int target, input int maxc);
        int k = 0;
        while (starts.size() < target && k < maxc) begin tick(); k++; end
        check("timeout_start", starts.size() >= target, 1);
    endtask

    task automatic rd(input int ch);
        cpu_rd = 1'b1;
        cpu_rd_ch = CW'(ch);
        tick();
        cpu_rd = 1'b0;
    endtask

    initial begin
        int exp2[6] = '{0, 1, 3, 0, 1, 3};
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_zero("rst_init");
        rst = 1'b1;
        tick(); tick();

        // Single channel pass
        eoc_cnt = 0; done_cnt = 0; starts.delete();
        ch_mask = 4'b0001; data_mode = 1; data_fix = 8'h5A;
        scan_en = 1'b1; tick(); scan_en = 1'b0;
        wait_idle(40);
        check("t1_eoc_cnt", eoc_cnt, 1);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_start_ch", starts.size() == 1 ? starts[0] : -1, 0);
        rd(0);
        check("t1_rd_data", cpu_rd_data, 8'h5A);
        check("t1_rd_valid", cpu_rd_valid, 1);
        rd(0);
        check("t1_rd_valid2", cpu_rd_valid, 0);

        // Round-robin over mask 1011
        do_reset();
        ch_mask = 4'b1011; data_mode = 2; scan_en = 1'b1;
        wait_eocs(6, 120);
        scan_en = 1'b0;
        wait_idle(40);
        for (int i = 0; i < 6; i++) check("t2_seq", starts.size() > i ? starts[i] : -1, exp2[i]);
        check("t2_done_cnt", done_cnt, 2);
        rd(0); check("t2_res0", cpu_rd_data, 8'h10);
        rd(1); check("t2_res1", cpu_rd_data, 8'h11);
        rd(3); check("t2_res3", cpu_rd_data, 8'h13);

        // Overrun on a continuously scanned channel
        do_reset();
        ch_mask = 4'b0100; data_mode = 0; scan_en = 1'b1;
        wait_eocs(1, 40);
        check("t3_ovr_first", ovr, 4'b0000);
        wait_eocs(2, 40);
        check("t3_ovr_second", ovr, 4'b0100);
        scan_en = 1'b0;
        wait_idle(40);
        rd(2);
        check("t3_ovr_sticky", ovr, 4'b0100);

        // Stop during the ch1 conversion
        do_reset();
        ch_mask = 4'b1111; scan_en = 1'b1;
        wait_starts(2, 60);
        repeat (3) tick();
        scan_en = 1'b0;
        wait_idle(40);
        repeat (4) tick();
        check("t4_starts", starts.size(), 2);
        check("t4_last_ch", starts.size() == 2 ? starts[1] : -1, 1);
        check("t4_eoc_cnt", eoc_cnt, 2);
        check("t4_done_cnt", done_cnt, 0);

        // Reset during a conversion
        do_reset();
        ch_mask = 4'b1111; scan_en = 1'b1;
        wait_starts(3, 60);
        repeat (2) tick();
        scan_en = 1'b0;
        do_reset();
        repeat (12) tick();
        check("t5_no_eoc", eoc_cnt, 0);
        scan_en = 1'b1;
        wait_starts(1, 20);
        check("t5_restart_ch", starts.size() > 0 ? starts[0] : -1, 0);
        scan_en = 1'b0;
        wait_idle(40);

`ifdef ADC_SCAN_AVG_EN
        do_reset();
        ch_mask = 4'b0001; data_mode = 1; data_fix = 8'h40;
        scan_en = 1'b1; tick(); scan_en = 1'b0;
        wait_idle(40);
        data_fix = 8'h81;
        scan_en = 1'b1; tick(); scan_en = 1'b0;
        wait_idle(40);
        rd(0);
        check("t6_avg", cpu_rd_data, 8'h61);
`endif

        // Random scanning, mask changes, stops and reads
        do_reset();
        data_mode = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) do_reset();
            if ($urandom_range(0, 29) == 0) ch_mask = 4'($urandom);
            scan_en   = ($urandom_range(0, 19) != 0);
            cpu_rd    = ($urandom_range(0, 3) == 0);
            cpu_rd_ch = 2'($urandom);
            tick();
        end
        cpu_rd = 1'b0;
        scan_en = 1'b0;
        wait_idle(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
